// File: rtl/nn_layer_pkg.sv
// Shared definitions for the neural-network layer plumbing: sequencer state
// encoding and the neuron-count to index-width helper.
package nn_layer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } seq_state_t;

  // Index counter width for an NN-word layer; never narrower than one bit.
  function automatic int idx_width(input int nn);
    return (nn > 1) ? $clog2(nn) : 1;
  endfunction

endpackage

// File: rtl/layer_sequencer.sv
// Captures one layer's parallel neuron outputs and replays them one word per
// cycle to the next layer. Define LAYER_SEQ_OVERRUN_DET_EN for the overrun flag.
module layer_sequencer
  import nn_layer_pkg::*;
#(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  output logic                    o_valid,
  output logic [dataWidth-1:0]    o_data,
  output logic                    busy,
  output logic                    done
`ifdef LAYER_SEQ_OVERRUN_DET_EN
  ,
  output logic                    overrun
`endif
);

  localparam int            IW       = idx_width(NN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

  seq_state_t           state_q, state_d;
  logic [IW-1:0]        idx_q;
  logic [dataWidth-1:0] hold_q [NN];
  logic                 done_q;
  logic                 capture, advance, last_word;

  // Only bit 0 triggers a capture; all neurons of a layer finish together.
  logic unused_valid_bits;
  assign unused_valid_bits = ^i_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    advance   = 1'b0;
    last_word = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid[0]) begin
          capture = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (idx_q == LAST_IDX) begin
          // A trigger on the final word chains straight into the next layer burst.
          last_word = 1'b1;
          capture   = i_valid[0];
          state_d   = i_valid[0] ? SHIFT : IDLE;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      for (int k = 0; k < NN; k++) hold_q[k] <= '0;
    end else if (capture) begin
      idx_q <= '0;
      for (int k = 0; k < NN; k++) hold_q[k] <= i_data[k*dataWidth +: dataWidth];
    end else if (advance) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= last_word;
  end

`ifdef LAYER_SEQ_OVERRUN_DET_EN
  // Sticky: a trigger arriving before the current burst has finished.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun <= 1'b0;
    else if (state_q == SHIFT && !last_word && i_valid[0]) overrun <= 1'b1;
  end
`endif

  // idx stays on the last word in IDLE, so o_data keeps showing it.
  assign o_valid = (state_q == SHIFT);
  assign busy    = (state_q == SHIFT);
  assign o_data  = hold_q[idx_q];
  assign done    = done_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed self-checking bench for layer_sequencer (NN=4 and NN=1 instances).
module tb_layer_sequencer;

  localparam int NN = 4;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NN-1:0]    i_valid;
  logic [NN*DW-1:0] i_data;
  logic             o_valid, busy, done;
  logic [DW-1:0]    o_data;
  logic             i_valid1;
  logic [DW-1:0]    i_data1;
  logic             o_valid1, busy1, done1;
  logic [DW-1:0]    o_data1;
`ifdef LAYER_SEQ_OVERRUN_DET_EN
  logic             overrun, overrun1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  layer_sequencer #(.NN(NN), .dataWidth(DW)) u_dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .o_data(o_data), .busy(busy), .done(done)
`ifdef LAYER_SEQ_OVERRUN_DET_EN
    , .overrun(overrun)
`endif
  );

  layer_sequencer #(.NN(1), .dataWidth(DW)) u_dut1 (
    .clk(clk), .rst(rst), .i_valid(i_valid1), .i_data(i_data1),
    .o_valid(o_valid1), .o_data(o_data1), .busy(busy1), .done(done1)
`ifdef LAYER_SEQ_OVERRUN_DET_EN
    , .overrun(overrun1)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a trigger for one edge; returns on the first word cycle.
  task automatic capture(input logic [NN*DW-1:0] d);
    i_data  = d;
    i_valid = 4'hF;
    step();
    i_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = '0; i_data = '0; i_valid1 = 1'b0; i_data1 = '0;
    #2;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
    n_cmp++; if (o_data !== 16'h0) begin n_err++; $display("FAIL reset_o_data got %h want 0000", o_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
`ifdef LAYER_SEQ_OVERRUN_DET_EN
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b want 0", overrun); end
`endif
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_stream();
    capture(64'h0004_0003_0002_0001);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %b want 1", k, o_valid); end
      n_cmp++; if (o_data !== 16'(k + 1)) begin n_err++; $display("FAIL stream_data[%0d] got %h want %h", k, o_data, 16'(k + 1)); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL stream_busy[%0d] got %b want 1", k, busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL stream_early_done[%0d] got %b want 0", k, done); end
      step();
    end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL stream_end_valid got %b want 0", o_valid); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stream_done got %b want 1", done); end
    n_cmp++; if (o_data !== 16'h0004) begin n_err++; $display("FAIL stream_hold_data got %h want 0004", o_data); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL stream_done_width got %b want 0", done); end
    step();
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    capture(64'h0004_0003_0002_0001);
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d] got %b want 1", k, o_valid); end
      n_cmp++; if (o_data !== 16'(k + 1)) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", k, o_data, 16'(k + 1)); end
      if (done === 1'b1) n_done++;
      if (k == 3) begin
        i_data  = 64'h0008_0007_0006_0005;
        i_valid = 4'hF;
      end else begin
        i_valid = '0;
      end
      step();
    end
    if (done === 1'b1) n_done++;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid got %b want 0", o_valid); end
    n_cmp++; if (n_done != 2) begin n_err++; $display("FAIL b2b_done_count got %0d want 2", n_done); end
    step(); step();
  endtask

  task automatic test_overrun();
    capture(64'h0004_0003_0002_0001);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (o_data !== 16'(k + 1)) begin n_err++; $display("FAIL ovr_data[%0d] got %h want %h", k, o_data, 16'(k + 1)); end
      n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid[%0d] got %b want 1", k, o_valid); end
      if (k == 1) begin
        i_data  = 64'hFFFF_EEEE_DDDD_CCCC;
        i_valid = 4'hF;
      end else begin
        i_valid = '0;
      end
      step();
    end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL ovr_end_valid got %b want 0", o_valid); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ovr_done got %b want 1", done); end
    step(); step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovr_idle_busy got %b want 0", busy); end
`ifdef LAYER_SEQ_OVERRUN_DET_EN
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag got %b want 1", overrun); end
    rst = 1'b1;
    #1;
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_flag_clear got %b want 0", overrun); end
    step();
    rst = 1'b0;
    step();
`endif
  endtask

  task automatic test_reset_mid();
    capture(64'h0004_0003_0002_0001);
    step(); step();
    n_cmp++; if (o_data !== 16'h0003) begin n_err++; $display("FAIL rmid_pre_data got %h want 0003", o_data); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b want 0", o_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_cmp++; if (o_data !== 16'h0000) begin n_err++; $display("FAIL rmid_data got %h want 0000", o_data); end
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rmid_resume_valid[%0d] got %b want 0", k, o_valid); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rmid_done[%0d] got %b want 0", k, done); end
    end
  endtask

  task automatic test_no_capture();
    i_data  = 64'h0004_0003_0002_0001;
    i_valid = 4'hE;
    step();
    i_valid = '0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL nocap_valid[%0d] got %b want 0", k, o_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL nocap_busy[%0d] got %b want 0", k, busy); end
      step();
    end
  endtask

  task automatic test_nn1();
    i_data1  = 16'hABCD;
    i_valid1 = 1'b1;
    step();
    i_valid1 = 1'b0;
    n_cmp++; if (o_valid1 !== 1'b1) begin n_err++; $display("FAIL nn1_valid got %b want 1", o_valid1); end
    n_cmp++; if (o_data1 !== 16'hABCD) begin n_err++; $display("FAIL nn1_data got %h want abcd", o_data1); end
    n_cmp++; if (done1 !== 1'b0) begin n_err++; $display("FAIL nn1_early_done got %b want 0", done1); end
    step();
    n_cmp++; if (o_valid1 !== 1'b0) begin n_err++; $display("FAIL nn1_end_valid got %b want 0", o_valid1); end
    n_cmp++; if (done1 !== 1'b1) begin n_err++; $display("FAIL nn1_done got %b want 1", done1); end
    n_cmp++; if (o_data1 !== 16'hABCD) begin n_err++; $display("FAIL nn1_hold_data got %h want abcd", o_data1); end
    step();
    n_cmp++; if (done1 !== 1'b0) begin n_err++; $display("FAIL nn1_done_width got %b want 0", done1); end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_single_stream();
    test_no_capture();
    test_nn1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
